// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, issues reads to a synchronous instruction memory (data one
// cycle after the request) and buffers responses in a 2-entry skid FIFO that
// feeds the IF/ID register through a valid/ready handshake. A redirect
// flushes the FIFO, drops any in-flight response and restarts fetch.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     instruction memory read request and address (out)
//   imem_rdata        instruction memory read data (in)
//   redirect/_pc      branch/jump restart request and target (in)
//   out_valid/ready   IF/ID handshake
//   out_pc_4          head instruction address + 4
//   out_instruction   head instruction word
//
// Build option: define FETCH_BYPASS_EN to forward a response straight to
// out_* when the FIFO is empty (1-cycle fetch latency instead of 2).
module fetch_unit #(
   parameter int unsigned          PC_WIDTH = 12,
   parameter logic [PC_WIDTH-1:0]  RESET_PC = PC_WIDTH'(0)
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [31:0]         imem_rdata,
   input  logic                redirect,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PC_WIDTH-1:0] out_pc_4,
   output logic [31:0]         out_instruction
);

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned DEPTH   = 2;

   typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_HOLD} state_e;

   state_e                state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [PC_WIDTH-1:0]   req_pc_q, req_pc_d;
   logic                  inflight_q, inflight_d;
   logic                  epoch_q, epoch_d;
   logic                  req_epoch_q, req_epoch_d;
   logic [1:0]            count_q, count_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [PC_WIDTH-1:0]   fifo_pc4_q [DEPTH];
   logic [PC_WIDTH-1:0]   fifo_pc4_d [DEPTH];
   logic [INSTR_W-1:0]    fifo_instr_q [DEPTH];
   logic [INSTR_W-1:0]    fifo_instr_d [DEPTH];

   logic                  resp_ok;
   logic [PC_WIDTH-1:0]   resp_pc_4;
   logic                  push;
   logic                  pop;
   logic                  issue;
   logic [2:0]            occ_next;

   // A response is usable only if it belongs to the current epoch and no
   // redirect is flushing the stage this cycle.
   assign resp_ok   = inflight_q & (req_epoch_q == epoch_q) & ~redirect;
   assign resp_pc_4 = req_pc_q + PC_WIDTH'(4);

`ifdef FETCH_BYPASS_EN
   logic bypass;
   assign bypass          = (count_q == 2'd0) & resp_ok;
   assign out_valid       = ~redirect & ((count_q != 2'd0) | bypass);
   assign out_pc_4        = bypass ? resp_pc_4  : fifo_pc4_q[rd_ptr_q];
   assign out_instruction = bypass ? imem_rdata : fifo_instr_q[rd_ptr_q];
   assign pop             = out_valid & out_ready & ~redirect;
   // A bypassed response that is consumed immediately never enters the FIFO.
   assign push            = resp_ok & ~(bypass & pop);
`else
   assign out_valid       = ~redirect & (count_q != 2'd0);
   assign out_pc_4        = fifo_pc4_q[rd_ptr_q];
   assign out_instruction = fifo_instr_q[rd_ptr_q];
   assign pop             = out_valid & out_ready & ~redirect;
   assign push            = resp_ok;
`endif

   // Occupancy after this cycle's pop, counting the in-flight response.
   assign occ_next  = 3'({1'b0, count_q}) + 3'(inflight_q) - 3'(pop);
   assign issue     = (state_q != ST_RESET) & ~redirect & (occ_next < 3'd2);
   assign imem_req  = issue;
   assign imem_addr = pc_q;

   // Next-state logic for PC, request tracking, FIFO and FSM.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      inflight_d   = inflight_q;
      epoch_d      = epoch_q;
      req_epoch_d  = req_epoch_q;
      count_d      = count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      fifo_pc4_d   = fifo_pc4_q;
      fifo_instr_d = fifo_instr_q;

      if (redirect) begin
         count_d    = 2'd0;
         inflight_d = 1'b0;
         epoch_d    = ~epoch_q;
         pc_d       = redirect_pc;
         wr_ptr_d   = rd_ptr_q;
      end else begin
         inflight_d = issue;
         if (issue) begin
            req_pc_d    = pc_q;
            req_epoch_d = epoch_q;
            pc_d        = pc_q + PC_WIDTH'(4);
         end
         if (push) begin
            fifo_pc4_d[wr_ptr_q]   = resp_pc_4;
            fifo_instr_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d               = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + 2'(push) - 2'(pop);
      end

      case (state_q)
         ST_RESET: state_d = ST_RUN;
         ST_RUN:   if (!redirect && occ_next == 3'd2) state_d = ST_HOLD;
         ST_HOLD:  if (pop || redirect) state_d = ST_RUN;
         default:  state_d = ST_RESET;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RESET;
         pc_q        <= RESET_PC;
         req_pc_q    <= PC_WIDTH'(0);
         inflight_q  <= 1'b0;
         epoch_q     <= 1'b0;
         req_epoch_q <= 1'b0;
         count_q     <= 2'd0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc4_q[i]   <= PC_WIDTH'(0);
            fifo_instr_q[i] <= INSTR_W'(0);
         end
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         inflight_q   <= inflight_d;
         epoch_q      <= epoch_d;
         req_epoch_q  <= req_epoch_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_pc4_q   <= fifo_pc4_d;
         fifo_instr_q <= fifo_instr_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected (pc_4, instruction) pairs are queued
// by the stimulus process and consumed by a monitor on every accepted output.
module tb_fetch_unit;

   localparam int unsigned PC_W = 12;
   localparam logic [19:0] TAG  = 20'hABCDE;

   typedef struct packed {
      logic [PC_W-1:0] pc4;
      logic [31:0]     instr;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic            redirect;
   logic [PC_W-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc_4;
   logic [31:0]     out_instruction;

   int   n_checks;
   int   n_fail;
   int   cyc;
   exp_t sb_q[$];
   exp_t mon_e;

   fetch_unit #(.PC_WIDTH(PC_W), .RESET_PC(12'h000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc_4(out_pc_4), .out_instruction(out_instruction)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous instruction memory: word tagged with its own address.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= {TAG, imem_addr};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_pc4(input logic [PC_W-1:0] pc4);
      exp_t e;
      logic [PC_W-1:0] a;
      a       = pc4 - 12'd4;
      e.pc4   = pc4;
      e.instr = {TAG, a};
      sb_q.push_back(e);
   endtask

   task automatic step(input logic rdy, input logic rd, input logic [PC_W-1:0] rpc);
      @(posedge clk);
      cyc++;
      #1;
      out_ready   = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      @(negedge clk);
   endtask

   // Monitor: compare every accepted output against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !redirect) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got pc_4 %h expected none (cycle %0d)", out_pc_4, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            chk("out_pc_4", 32'(out_pc_4), 32'(mon_e.pc4));
            chk("out_instruction", out_instruction, mon_e.instr);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      cyc         = 0;
      rst_n       = 1'b0;
      out_ready   = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;

      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_out_pc_4", 32'(out_pc_4), 32'd0);
      chk("rst_out_instruction", out_instruction, 32'd0);

      foreach (sb_q[i]) sb_q.delete(i);
      for (int k = 1; k <= 8; k++) expect_pc4(12'(4 * k));
      expect_pc4(12'h104); expect_pc4(12'h108); expect_pc4(12'h10C);
      expect_pc4(12'hFFC); expect_pc4(12'h000); expect_pc4(12'h004);
      expect_pc4(12'h008);

      rst_n = 1'b1;
      cyc   = 0;
      step(1'b1, 1'b0, 12'h0);
      chk("c1_imem_req", 32'(imem_req), 32'd1);
      chk("c1_imem_addr", 32'(imem_addr), 32'h000);
      chk("c1_out_valid", 32'(out_valid), 32'd0);
      step(1'b1, 1'b0, 12'h0);
`ifdef FETCH_BYPASS_EN
      chk("c2_out_valid", 32'(out_valid), 32'd1);
`else
      chk("c2_out_valid", 32'(out_valid), 32'd0);
`endif
      step(1'b1, 1'b0, 12'h0);
      chk("c3_out_valid", 32'(out_valid), 32'd1);
      for (int c = 4; c <= 6; c++) step(1'b1, 1'b0, 12'h0);

      // Backpressure: buffer fills, fetch stops, head holds.
      for (int c = 7; c <= 11; c++) begin
         step(1'b0, 1'b0, 12'h0);
         chk("bp_imem_req", 32'(imem_req), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_pc_4", 32'(out_pc_4), 32'h014);
      end
      for (int c = 12; c <= 15; c++) step(1'b1, 1'b0, 12'h0);

      // Redirect with one entry buffered and a response arriving.
      step(1'b0, 1'b1, 12'h100);
      chk("rd1_out_valid", 32'(out_valid), 32'd0);
      chk("rd1_imem_req", 32'(imem_req), 32'd0);
      step(1'b1, 1'b0, 12'h0);
      chk("rd1_next_req", 32'(imem_req), 32'd1);
      chk("rd1_next_addr", 32'(imem_addr), 32'h100);
      chk("rd1_next_valid", 32'(out_valid), 32'd0);
      step(1'b1, 1'b0, 12'h0);
      step(1'b1, 1'b0, 12'h0);
      chk("rd1_n3_valid", 32'(out_valid), 32'd1);
      chk("rd1_n3_pc_4", 32'(out_pc_4), 32'h104);
      step(1'b1, 1'b0, 12'h0);
      step(1'b1, 1'b0, 12'h0);

      // Redirect coincident with a would-be pop, into the wrap region.
      step(1'b1, 1'b1, 12'hFF8);
      chk("rd2_out_valid", 32'(out_valid), 32'd0);
      chk("rd2_imem_req", 32'(imem_req), 32'd0);
      step(1'b1, 1'b0, 12'h0);
      chk("rd2_next_addr", 32'(imem_addr), 32'hFF8);
      for (int c = 24; c <= 28; c++) step(1'b1, 1'b0, 12'h0);

      // Asynchronous reset mid-cycle.
      @(posedge clk);
      cyc++;
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_imem_req", 32'(imem_req), 32'd0);
      chk("pre_restart_sb_empty", 32'(sb_q.size()), 32'd0);
      repeat (2) @(negedge clk);

      for (int k = 1; k <= 4; k++) expect_pc4(12'(4 * k));
      rst_n = 1'b1;
      cyc   = 0;
      step(1'b1, 1'b0, 12'h0);
      chk("rs_c1_addr", 32'(imem_addr), 32'h000);
      chk("rs_c1_req", 32'(imem_req), 32'd1);
      step(1'b1, 1'b0, 12'h0);
`ifdef FETCH_BYPASS_EN
      chk("rs_c2_out_valid", 32'(out_valid), 32'd1);
`else
      chk("rs_c2_out_valid", 32'(out_valid), 32'd0);
`endif
      step(1'b1, 1'b0, 12'h0);
      chk("rs_c3_out_valid", 32'(out_valid), 32'd1);
      for (int c = 4; c <= 6; c++) step(1'b1, 1'b0, 12'h0);
      step(1'b0, 1'b0, 12'h0);
      chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
